// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: requester indices and FSM state encodings shared by the SDRAM burst arbiter.
package mem_arbiter_pkg;
  localparam int NREQ = 4;
  localparam logic [1:0] REQ_CMD = 2'd0;
  localparam logic [1:0] REQ_WGT = 2'd1;
  localparam logic [1:0] REQ_IMG = 2'd2;
  localparam logic [1:0] REQ_OUT = 2'd3;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    BURST   = 2'b10,
    RELEASE = 2'b11
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: first set request searching circularly from ptr+1; ptr=3 gives plain lowest-index priority.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] onehot,
  output logic [1:0]      idx
);
  logic [1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = ptr + 2'(k);
      idx = req[j] ? j : idx;
    end
    onehot = |req ? 4'b0001 << idx : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: four-way SDRAM burst arbiter, round-robin by default.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int LEN_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        grant,
  output logic [1:0]             grant_id,
  output logic                   mem_cmd_valid,
  input  logic                   mem_cmd_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LEN_W-1:0]       mem_len,
  output logic                   mem_we,
  input  logic                   mem_beat,
  output logic                   burst_done,
  output logic                   busy
);
  state_t              state_q;
  logic [NREQ-1:0]     grant_q, pick_oh;
  logic [1:0]          grant_id_q, pick_idx, ptr;
  logic                valid_q, we_q, done_q, busy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q, beat_cnt_q;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr = REQ_OUT;
`else
  logic [1:0] rr_ptr_q;
  assign ptr = rr_ptr_q;
`endif
  rr_pick u_pick (.req(req), .ptr(ptr), .onehot(pick_oh), .idx(pick_idx));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= REQ_OUT;
`endif
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          grant_q    <= pick_oh;
          grant_id_q <= pick_idx;
          addr_q     <= req_addr[pick_idx*ADDR_W +: ADDR_W];
          len_q      <= req_len[pick_idx*LEN_W +: LEN_W];
          we_q       <= req_we[pick_idx];
          valid_q    <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: if (mem_cmd_ready) begin
          valid_q    <= 1'b0;
          beat_cnt_q <= len_q;
          done_q     <= len_q == '0;
          state_q    <= len_q == '0 ? RELEASE : BURST;
        end
        BURST: if (mem_beat) begin
          beat_cnt_q <= beat_cnt_q - 1'b1;
          done_q     <= beat_cnt_q == LEN_W'(1);
          state_q    <= beat_cnt_q == LEN_W'(1) ? RELEASE : BURST;
        end
        RELEASE: begin
          grant_q <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_ptr_q <= grant_id_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign grant         = grant_q;
  assign grant_id      = grant_id_q;
  assign mem_cmd_valid = valid_q;
  assign mem_addr      = addr_q;
  assign mem_len       = len_q;
  assign mem_we        = we_q;
  assign burst_done    = done_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, backpressure, zero-length bursts and async reset.
module tb_mem_arbiter;
  localparam int AW = 30;
  localparam int LW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0, req_we = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic [4*LW-1:0] req_len = '0;
  logic [3:0]    grant;
  logic [1:0]    grant_id;
  logic          mem_cmd_valid, mem_cmd_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_len;
  logic          mem_we, mem_beat = 1'b0, burst_done, busy;
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .grant(grant), .grant_id(grant_id),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_we(mem_we),
    .mem_beat(mem_beat), .burst_done(burst_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    req_addr[id*AW +: AW] = a;
    req_len[id*LW +: LW] = l;
    req_we[id] = w;
  endtask

  task automatic chk_issue(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    chk("grant", grant, 64'(4'b0001 << id));
    chk("grant_id", grant_id, 64'(id));
    chk("cmd_valid", mem_cmd_valid, 1);
    chk("mem_addr", mem_addr, a);
    chk("mem_len", mem_len, l);
    chk("mem_we", mem_we, w);
    chk("busy_issue", busy, 1);
  endtask

  task automatic do_burst(input int id, input int len);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    chk("valid_drop", mem_cmd_valid, 0);
    chk("done_zero", burst_done, 64'(len == 0));
    for (int i = 0; i < len; i++) begin
      mem_beat = 1'b1;
      tick();
      chk("grant_hold", grant, 64'(4'b0001 << id));
      chk("beat_done", burst_done, 64'(i == len - 1));
    end
    mem_beat = 1'b0;
    chk("busy_release", busy, 1);
    tick();
    chk("done_clr", burst_done, 0);
    chk("grant_clr", grant, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_grant", grant, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_valid", mem_cmd_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_len", mem_len, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    int exp_id;
    tick();
    tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // all four requesting, len=2 each
    for (int id = 0; id < 4; id++) set_req(id, AW'(32'h100 * (id + 1)), 8'd2, 1'b0);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % 4;
`endif
      tick();
      chk_issue(exp_id, AW'(32'h100 * (exp_id + 1)), 8'd2, 1'b0);
      do_burst(exp_id, 2);
    end
    req = 4'b0000;

    // single request on requester 1
    set_req(1, 30'h0001000, 8'd4, 1'b0);
    req = 4'b0010;
    tick();
    chk_issue(1, 30'h0001000, 8'd4, 1'b0);
    req = 4'b0000;
    do_burst(1, 4);

    // backpressure: ready low for 5 cycles
    set_req(2, 30'h2ABCDEF, 8'd3, 1'b1);
    req = 4'b0100;
    tick();
    chk_issue(2, 30'h2ABCDEF, 8'd3, 1'b1);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_issue(2, 30'h2ABCDEF, 8'd3, 1'b1);
    end
    do_burst(2, 3);

    // zero-length write on requester 3
    set_req(3, 30'h3000000, 8'd0, 1'b1);
    req = 4'b1000;
    tick();
    chk_issue(3, 30'h3000000, 8'd0, 1'b1);
    req = 4'b0000;
    do_burst(3, 0);

    // requester 2 drops req mid-burst, then stray beats in IDLE
    set_req(2, 30'h0002200, 8'd8, 1'b0);
    req = 4'b0100;
    tick();
    chk_issue(2, 30'h0002200, 8'd8, 1'b0);
    req = 4'b0000;
    do_burst(2, 8);
    mem_beat = 1'b1;
    tick();
    tick();
    mem_beat = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_valid", mem_cmd_valid, 0);
    chk("stray_done", burst_done, 0);
    chk("stray_grant", grant, 0);

    // asynchronous reset after 3 of 8 beats
    set_req(1, 30'h0005550, 8'd8, 1'b1);
    req = 4'b0010;
    tick();
    chk_issue(1, 30'h0005550, 8'd8, 1'b1);
    req = 4'b0000;
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    mem_beat = 1'b1;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    mem_beat = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    rst = 1'b0;
    set_req(0, 30'h0000040, 8'd2, 1'b0);
    req = 4'b0001;
    tick();
    chk_issue(0, 30'h0000040, 8'd2, 1'b0);
    req = 4'b0000;
    do_burst(0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single SDRAM burst port between four requesters: 0 command fetch, 1 weight read, 2 image read, 3 outbuf write.
- Latches the winner's address, length and direction, then issues one burst command to the memory controller.
- Holds the grant until every beat of that burst has been transferred.
- Sits between the command sequencer / engine datapath and the memory interface. Default policy is round-robin.

Parameters:
- ADDR_W, 30, width of each requester address and of mem_addr.
- LEN_W, 8, width of burst length in beats.
- NREQ, 4, number of requesters. Fixed at 4; grant_id is 2 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req  in  4  per-requester burst request, level; held until grant
- req_we  in  4  per-requester direction, 1 = write
- req_addr  in  4*ADDR_W  flattened start addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_len  in  4*LEN_W  flattened burst lengths in beats
- grant  out  4  one-hot grant, held for the whole transaction
- grant_id  out  2  binary index of the granted requester
- mem_cmd_valid  out  1  burst command valid to memory controller
- mem_cmd_ready  in  1  memory controller accepts command
- mem_addr  out  ADDR_W  latched start address
- mem_len  out  LEN_W  latched length
- mem_we  out  1  latched direction
- mem_beat  in  1  one data beat transferred this cycle (read or write)
- burst_done  out  1  one-cycle pulse when the last beat is transferred
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk.
- On reset: state=IDLE; grant=0, grant_id=0, mem_cmd_valid=0, mem_addr=0, mem_len=0, mem_we=0, burst_done=0, busy=0; rr_ptr=3, so requester 0 is first in the search; beat_cnt=0.
- All outputs are registered.
- Reset mid-operation aborts immediately. No completion pulse is generated.
- States: IDLE, ISSUE, BURST, RELEASE.
- IDLE:
  - If req != 0, choose the winner: the first set bit searching circularly from rr_ptr+1.
  - Latch its addr/len/we into mem_*; set grant/grant_id; set mem_cmd_valid=1; go to ISSUE.
  - Latency from req rising to mem_cmd_valid is 1 cycle.
- ISSUE:
  - Hold mem_cmd_valid and all mem_* stable until mem_cmd_ready.
  - On accept: mem_cmd_valid=0 and beat_cnt=mem_len.
  - If mem_len==0, go to RELEASE (zero-beat burst, no data phase). Otherwise go to BURST.
- BURST:
  - Each mem_beat decrements beat_cnt.
  - On mem_beat with beat_cnt==1: burst_done=1 next cycle, go to RELEASE.
  - mem_beat in any state other than BURST is ignored.
- RELEASE (exactly 1 cycle):
  - grant=0; rr_ptr=grant_id; burst_done pulse visible this cycle; return to IDLE.
  - The minimum gap between consecutive grants is therefore 1 idle-sampling cycle. Back-to-back transaction cost = 3 cycles + handshake + beats.
- Requester rules:
  - req deasserted after grant does not abort; the burst completes.
  - req changes while granted are ignored until IDLE.
  - A requester must drop req in the cycle after burst_done if it has no further work. Otherwise it is treated as a new request.
- Simultaneous events:
  - All four requests in IDLE: one winner, strictly per the round-robin order.
  - mem_cmd_ready asserted in the same cycle mem_cmd_valid rises is legal.
- Width: beat_cnt is LEN_W bits and never wraps; a decrement at 0 is impossible by construction.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins (command fetch always first); rr_ptr is not updated.
- Undefined: round-robin as above.

Decomposition:
- Shared macros header holds requester index constants (REQ_CMD=0, REQ_WGT=1, REQ_IMG=2, REQ_OUT=3) and the state encodings (IDLE=2'b00, ISSUE=2'b01, BURST=2'b10, RELEASE=2'b11).
- One combinational sub-module, rr_pick (inputs: 4-bit req and 2-bit ptr; outputs: 4-bit one-hot and 2-bit index), shared by both policies via the macro.

Test Plan:
- Single request: req=4'b0010, addr=0x0001000, len=4 -> grant=0010 one cycle later, mem_cmd_valid until ready, 4 beats, burst_done pulse, busy drops after RELEASE.
- All requesting: req=4'b1111 continuously, len=2 each -> grant order 0,1,2,3,0 (fixed-prio build: always 0).
- Backpressure: mem_cmd_ready low 5 cycles -> mem_addr/len/we and mem_cmd_valid stable all 5 cycles.
- Zero length: len=0 on requester 3, we=1 -> command issued, no beats awaited, RELEASE directly, burst_done pulses.
- Drop/glitch: requester 2 drops req mid-burst (len=8) -> grant held through 8 beats; stray mem_beat in IDLE -> no state change.
- Reset mid-BURST (3 of 8 beats done) -> all outputs to reset values asynchronously; after release, req=0001 granted normally.
